operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Operand-fetch stage of the 16-bit CPU, directly upstream of the ALU operand muxes.
//  - Holds the 4 x 16-bit register bank.
//  - Accepts one decoded instruction word per handshake and reads rs1/rs2.
//  - Forwards a same-cycle writeback.
//  - Presents registered opcode, rd, operand A and operand B to the execute stage.
// PARAMETERS
//  ZERO_R0  1  1: r0 reads as 16'h0000 and writes to r0 are dropped; 0: r0 is a normal register
//  BYPASS   1  1: same-cycle writeback is forwarded into the captured operands; 0: old value is read
// PORTS
//  i_clk      in   1   clock; everything updates on the rising edge
//  i_rst_n    in   1   synchronous, active-low reset
//  i_valid    in   1   upstream instruction valid
//  o_ready    out  1   stage can accept an instruction this cycle
//  i_instr    in   16  [0:3] opcode, [4:5] rd, [6:7] rs1, [8:9] rs2, [10:15] imm6
//  i_wb_en    in   1   writeback enable
//  i_wb_idx   in   2   writeback register index
//  i_wb_data  in   16  writeback data
//  o_valid    out  1   output bundle valid
//  i_ready    in   1   execute stage accepts the bundle
//  o_op       out  4   captured opcode
//  o_rd       out  2   captured destination index
//  o_a        out  16  operand A = R[rs1]
//  o_b        out  16  operand B: R[rs2] if opcode[0]==0, else sign-extended imm6
// BEHAVIOUR
//  - Bit order: all vectors are [0:N-1] with bit 0 as the MSB.
//  - Reset: while i_rst_n==0 at a rising edge:
//    - R0..R3, o_op, o_rd, o_a and o_b all go to 0.
//    - o_valid goes to 0.
//    - o_ready reads 1 on the first cycle after reset.
//  - Handshake:
//    - o_ready = !o_valid || i_ready (combinational).
//    - Capture happens when i_valid && o_ready; on the next edge o_valid=1 and the outputs load.
//    - The bundle retires when o_valid && i_ready with no capture; o_valid then goes to 0.
//    - Capture and retire in the same cycle leave o_valid at 1 and load the new bundle.
//    - Latency is 1 cycle; throughput is 1 per cycle when i_ready is held high.
//  - Hold: while o_valid && !i_ready, all outputs stay stable and o_ready=0.
//    - A held bundle is a snapshot; later writebacks do not update it.
//    - Hazards are upstream's responsibility.
//  - Writeback: when i_wb_en=1, R[i_wb_idx] gets i_wb_data at the edge.
//    - The write is independent of the handshake and of any stall.
//    - When ZERO_R0=1 and i_wb_idx==0, the write is ignored.
//  - Read: the bank is read combinationally with 4:1 word selects indexed by rs1/rs2.
//  - Bypass (BYPASS=1): if i_wb_en, rs==i_wb_idx and a capture happens in the same cycle, i_wb_data is captured.
//    - Applies to rs1 and rs2 independently.
//    - Not forwarded for idx 0 when ZERO_R0=1.
//  - Immediate: imm6 is sign-extended to 16 bits; 6'b100000 becomes 16'hFFE0.
//  - Reset mid-operation: the pending bundle is discarded, no handshake completes, and the bank is cleared.
// STRUCTURE
//  - Shared package: opcode width (4), register-index width (2), word width (16), and instruction field offsets.
//  - Sub-module reg_bank4:
//    - 4 x 16 storage with one write port and two combinational read ports.
//    - Read ports are built from the existing 4:1 word mux.
//    - Applies ZERO_R0 and BYPASS.
//  - Top level: handshake and output register, plus the imm/reg select for B using the existing 2:1 word mux.
// TESTING
//  - Reset then write r1=16'h1234, r2=16'h00FF; issue rs1=1, rs2=2, op=4'b0011 -> next cycle o_valid=1, o_a=1234, o_b=00FF.
//  - op=4'b1000, imm6=6'b111110 -> o_b=16'hFFFE; imm6=6'b011111 -> o_b=16'h001F.
//  - Same-cycle wb r3=16'hBEEF while capturing rs1=3 -> o_a=BEEF with BYPASS=1; old r3 with BYPASS=0.
//  - Write r0=16'hAAAA, then read rs1=0 -> o_a=0000 with ZERO_R0=1; AAAA with ZERO_R0=0.
//  - Hold i_ready=0 for 3 cycles with i_valid=1 and a wb to the held rs -> outputs stable, o_ready=0, only one bundle accepted.
//  - Back-to-back stream of 8 instructions with i_ready=1 -> 8 consecutive valid bundles.
//  - Stream of 8 with i_ready=0 on cycle 3, then assert i_rst_n=0 -> o_valid=0, o_ready=1 and all registers read 0 afterwards.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared widths, instruction field offsets and word-mux helpers
// for the operand-fetch stage of the 16-bit CPU.
package operand_fetch_pkg;

    localparam int OP_W    = 4;
    localparam int IDX_W   = 2;
    localparam int WORD_W  = 16;
    localparam int IMM_W   = 6;
    localparam int INSTR_W = 16;

    // Field offsets counted from bit 0, which is the MSB.
    localparam int OP_OFS  = 0;
    localparam int RD_OFS  = 4;
    localparam int RS1_OFS = 6;
    localparam int RS2_OFS = 8;
    localparam int IMM_OFS = 10;

    typedef logic [0:WORD_W-1] word_t;
    typedef logic [0:IDX_W-1]  idx_t;
    typedef logic [0:OP_W-1]   op_t;
    typedef logic [0:IMM_W-1]  imm_t;

    typedef struct packed {
        op_t   op;
        idx_t  rd;
        word_t a;
        word_t b;
    } of_bundle_t;

    function automatic word_t word_mux4(
        input word_t w0,
        input word_t w1,
        input word_t w2,
        input word_t w3,
        input idx_t  sel
    );
        word_t res;
        unique case (sel)
            2'd0:    res = w0;
            2'd1:    res = w1;
            2'd2:    res = w2;
            default: res = w3;
        endcase
        return res;
    endfunction

    function automatic word_t word_mux2(
        input word_t w0,
        input word_t w1,
        input logic  sel
    );
        return sel ? w1 : w0;
    endfunction

    // imm6 bit 0 is its sign bit.
    function automatic word_t sext_imm(input imm_t imm);
        return {{(WORD_W-IMM_W){imm[0]}}, imm};
    endfunction

endpackage

// File: rtl/operand_fetch_reg_bank4.sv
// 4 x 16-bit register bank: one write port, two combinational
// read ports with optional hardwired r0 and same-cycle forwarding.
module reg_bank4
    import operand_fetch_pkg::*;
#(
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_en,
    input  logic [0:IDX_W-1]  i_wb_idx,
    input  logic [0:WORD_W-1] i_wb_data,
    input  logic [0:IDX_W-1]  i_rs1,
    input  logic [0:IDX_W-1]  i_rs2,
    output logic [0:WORD_W-1] o_rd1,
    output logic [0:WORD_W-1] o_rd2
);

    word_t regs_q [4];
    word_t regs_d [4];
    logic  wr_ok;

    assign wr_ok = i_wb_en && !(ZERO_R0 && i_wb_idx == '0);

    // Next bank contents: apply the writeback, drop r0 writes if hardwired.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[i_wb_idx] = i_wb_data;
        end
    end

    // Bank storage, cleared by synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port 1: hardwired r0 wins, then forwarding, then stored word.
    always_comb begin
        o_rd1 = word_mux4(regs_q[0], regs_q[1], regs_q[2], regs_q[3], i_rs1);
        if (ZERO_R0 && i_rs1 == '0) begin
            o_rd1 = '0;
        end else if (BYPASS && i_wb_en && i_wb_idx == i_rs1) begin
            o_rd1 = i_wb_data;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        o_rd2 = word_mux4(regs_q[0], regs_q[1], regs_q[2], regs_q[3], i_rs2);
        if (ZERO_R0 && i_rs2 == '0) begin
            o_rd2 = '0;
        end else if (BYPASS && i_wb_en && i_wb_idx == i_rs2) begin
            o_rd2 = i_wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register bank read, valid/ready output
// register and operand B immediate/register select.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [0:INSTR_W-1] i_instr,
    input  logic               i_wb_en,
    input  logic [0:IDX_W-1]   i_wb_idx,
    input  logic [0:WORD_W-1]  i_wb_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [0:OP_W-1]    o_op,
    output logic [0:IDX_W-1]   o_rd,
    output logic [0:WORD_W-1]  o_a,
    output logic [0:WORD_W-1]  o_b
);

    op_t        f_op;
    idx_t       f_rd;
    idx_t       f_rs1;
    idx_t       f_rs2;
    imm_t       f_imm;
    word_t      rd1;
    word_t      rd2;
    word_t      b_val;
    logic       capture;
    logic       valid_q;
    logic       valid_d;
    of_bundle_t bundle_q;
    of_bundle_t bundle_d;

    assign f_op  = i_instr[OP_OFS  +: OP_W];
    assign f_rd  = i_instr[RD_OFS  +: IDX_W];
    assign f_rs1 = i_instr[RS1_OFS +: IDX_W];
    assign f_rs2 = i_instr[RS2_OFS +: IDX_W];
    assign f_imm = i_instr[IMM_OFS +: IMM_W];

    reg_bank4 #(
        .ZERO_R0 (ZERO_R0),
        .BYPASS  (BYPASS)
    ) u_bank (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wb_en   (i_wb_en),
        .i_wb_idx  (i_wb_idx),
        .i_wb_data (i_wb_data),
        .i_rs1     (f_rs1),
        .i_rs2     (f_rs2),
        .o_rd1     (rd1),
        .o_rd2     (rd2)
    );

    // Opcode bit 0 selects the sign-extended immediate for operand B.
    assign b_val   = word_mux2(rd2, sext_imm(f_imm), f_op[0]);
    assign o_ready = !valid_q || i_ready;
    assign capture = i_valid && o_ready;

    // Load on capture, drop valid on a retire without a new capture.
    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (capture) begin
            valid_d    = 1'b1;
            bundle_d.op = f_op;
            bundle_d.rd = f_rd;
            bundle_d.a  = rd1;
            bundle_d.b  = b_val;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign o_valid = valid_q;
    assign o_op    = bundle_q.op;
    assign o_rd    = bundle_q.rd;
    assign o_a     = bundle_q.a;
    assign o_b     = bundle_q.b;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: two instances (ZERO_R0/BYPASS = 1/1
// and 0/0) sharing stimulus, checked against a behavioural model.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] instr;
    logic        wb_en;
    logic [1:0]  wb_idx;
    logic [15:0] wb_data;

    logic        a_ready, a_valid, b_ready, b_valid;
    logic [3:0]  a_op, b_op;
    logic [1:0]  a_rd, b_rd;
    logic [15:0] a_a, a_b, b_a, b_b;

    int checks = 0;
    int errors = 0;
    int caps   = 0;

    always #5 clk = ~clk;

    operand_fetch #(.ZERO_R0(1'b1), .BYPASS(1'b1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(a_ready),
        .i_instr(instr), .i_wb_en(wb_en), .i_wb_idx(wb_idx),
        .i_wb_data(wb_data), .o_valid(a_valid), .i_ready(i_ready),
        .o_op(a_op), .o_rd(a_rd), .o_a(a_a), .o_b(a_b)
    );

    operand_fetch #(.ZERO_R0(1'b0), .BYPASS(1'b0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(b_ready),
        .i_instr(instr), .i_wb_en(wb_en), .i_wb_idx(wb_idx),
        .i_wb_data(wb_data), .o_valid(b_valid), .i_ready(i_ready),
        .o_op(b_op), .o_rd(b_rd), .o_a(b_a), .o_b(b_b)
    );

    // Model state, index 0 = u_a (1/1), index 1 = u_b (0/0).
    bit          zr [2] = '{1'b1, 1'b0};
    bit          bp [2] = '{1'b1, 1'b0};
    logic [15:0] mr [2][4];
    bit          mv [2];
    logic [3:0]  mop [2];
    logic [1:0]  mrd [2];
    logic [15:0] ma [2];
    logic [15:0] mb [2];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mread(input int m, input logic [1:0] rs);
        if (zr[m] && rs == 2'd0) return 16'h0000;
        if (bp[m] && wb_en && wb_idx == rs) return wb_data;
        return mr[m][rs];
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic [5:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Advance the model with the inputs the next rising edge will see.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit rdy;
            rdy = !mv[m] || i_ready;
            if (!rst_n) begin
                mv[m] = 0; mop[m] = 0; mrd[m] = 0; ma[m] = 0; mb[m] = 0;
                for (int k = 0; k < 4; k++) mr[m][k] = 16'h0000;
            end else begin
                if (i_valid && rdy) begin
                    logic [5:0] imm;
                    imm    = instr[5:0];
                    mv[m]  = 1;
                    mop[m] = instr[15:12];
                    mrd[m] = instr[11:10];
                    ma[m]  = mread(m, instr[9:8]);
                    mb[m]  = instr[15] ? {{10{imm[5]}}, imm} : mread(m, instr[7:6]);
                end else if (i_ready) begin
                    mv[m] = 0;
                end
                if (wb_en && !(zr[m] && wb_idx == 2'd0)) mr[m][wb_idx] = wb_data;
            end
        end
    endtask

    // Compare on the falling edge, then advance the model.
    initial begin
        for (int m = 0; m < 2; m++) begin
            mv[m] = 0; mop[m] = 0; mrd[m] = 0; ma[m] = 0; mb[m] = 0;
            for (int k = 0; k < 4; k++) mr[m][k] = 16'h0000;
        end
        forever begin
            @(negedge clk);
            chk("a.valid", {15'd0, a_valid}, {15'd0, mv[0]});
            chk("a.ready", {15'd0, a_ready}, {15'd0, !mv[0] || i_ready});
            chk("a.op", {12'd0, a_op}, {12'd0, mop[0]});
            chk("a.rd", {14'd0, a_rd}, {14'd0, mrd[0]});
            chk("a.a", a_a, ma[0]);
            chk("a.b", a_b, mb[0]);
            chk("b.valid", {15'd0, b_valid}, {15'd0, mv[1]});
            chk("b.ready", {15'd0, b_ready}, {15'd0, !mv[1] || i_ready});
            chk("b.op", {12'd0, b_op}, {12'd0, mop[1]});
            chk("b.rd", {14'd0, b_rd}, {14'd0, mrd[1]});
            chk("b.a", b_a, ma[1]);
            chk("b.b", b_b, mb[1]);
            if (rst_n && i_valid && a_ready) caps++;
            model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 0; instr = 0; wb_en = 0; wb_idx = 0; wb_data = 0;
    endtask

    task automatic wb(input logic [1:0] idx, input logic [15:0] d);
        wb_en = 1; wb_idx = idx; wb_data = d;
    endtask

    task automatic issue(input logic [15:0] ins);
        i_valid = 1; instr = ins;
    endtask

    initial begin
        int c0;
        rst_n = 0; i_ready = 1;
        idle();
        step();
        step();
        rst_n = 1;
        @(negedge clk);
        chk("rst.valid", {15'd0, a_valid}, 16'd0);
        chk("rst.ready", {15'd0, a_ready}, 16'd1);
        chk("rst.a", a_a, 16'h0000);

        // Basic read of r1/r2.
        step(); wb(2'd1, 16'h1234);
        step(); wb(2'd2, 16'h00FF);
        step(); idle(); issue(mk(4'b0011, 2'd1, 2'd1, 2'd2, 6'd0));
        step(); idle();
        @(negedge clk);
        chk("t1.valid", {15'd0, a_valid}, 16'd1);
        chk("t1.a", a_a, 16'h1234);
        chk("t1.b", a_b, 16'h00FF);
        chk("t1.b_b", b_b, 16'h00FF);

        // Immediates.
        step(); issue(mk(4'b1000, 2'd0, 2'd0, 2'd0, 6'b111110));
        step(); issue(mk(4'b1001, 2'd0, 2'd0, 2'd0, 6'b011111));
        @(negedge clk);
        chk("imm.neg", a_b, 16'hFFFE);
        step(); issue(mk(4'b1000, 2'd0, 2'd0, 2'd0, 6'b100000));
        @(negedge clk);
        chk("imm.pos", a_b, 16'h001F);
        step(); idle();
        @(negedge clk);
        chk("imm.min", a_b, 16'hFFE0);

        // Same-cycle writeback forwarding.
        step(); wb(2'd3, 16'h1111);
        step(); idle(); wb(2'd3, 16'hBEEF); issue(mk(4'b0000, 2'd2, 2'd3, 2'd1, 6'd0));
        step(); idle();
        @(negedge clk);
        chk("byp.on", a_a, 16'hBEEF);
        chk("byp.off", b_a, 16'h1111);

        // r0 handling.
        step(); wb(2'd0, 16'hAAAA);
        step(); idle(); issue(mk(4'b0000, 2'd0, 2'd0, 2'd0, 6'd0));
        step(); idle();
        @(negedge clk);
        chk("r0.zero", a_a, 16'h0000);
        chk("r0.norm", b_a, 16'hAAAA);

        // Hold with a writeback to the held source.
        c0 = caps;
        step(); i_ready = 0; issue(mk(4'b0010, 2'd3, 2'd2, 2'd1, 6'd0));
        step(); issue(mk(4'b0001, 2'd0, 2'd1, 2'd1, 6'd0)); wb(2'd2, 16'h5555);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold.a", a_a, 16'h00FF);
            chk("hold.op", {12'd0, a_op}, 16'h0002);
            chk("hold.ready", {15'd0, a_ready}, 16'd0);
            step();
        end
        idle(); i_ready = 1;
        step();
        chk("hold.caps", 16'(caps - c0), 16'd1);

        // Back-to-back stream.
        c0 = caps;
        for (int i = 0; i <= 8; i++) begin
            step();
            if (i < 8) issue(mk(4'(i), 2'(i), 2'(i), 2'(3 - i % 4), 6'd0));
            else idle();
            if (i >= 1) begin
                @(negedge clk);
                chk("strm.valid", {15'd0, a_valid}, 16'd1);
                chk("strm.op", {12'd0, a_op}, 16'(i - 1));
            end
        end
        step();
        chk("strm.caps", 16'(caps - c0), 16'd8);

        // Stream with a stall, then reset mid-operation.
        for (int c = 0; c <= 8; c++) begin
            int idx;
            step();
            idx = (c > 3) ? c - 1 : c;
            i_ready = (c != 3);
            issue(mk(4'(idx), 2'd1, 2'(idx), 2'd2, 6'd0));
        end
        step(); rst_n = 0;
        step(); rst_n = 1; idle(); i_ready = 1;
        @(negedge clk);
        chk("mrst.valid", {15'd0, a_valid}, 16'd0);
        chk("mrst.ready", {15'd0, a_ready}, 16'd1);
        for (int k = 0; k <= 4; k++) begin
            step();
            if (k < 4) issue(mk(4'b0000, 2'd0, 2'(k), 2'(k), 6'd0));
            else idle();
            if (k >= 1) begin
                @(negedge clk);
                chk("mrst.a", a_a, 16'h0000);
                chk("mrst.bb", b_b, 16'h0000);
            end
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
